// File: rtl/dac_spi_pkg.sv
// Shared types, default parameters and width helper for the DAC serial transmitter.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int DEF_DATA_W  = 12;
  localparam int DEF_FRAME_W = 16;
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_GAP_CYC = 2;

  // Bits needed to hold a counter value up to max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dac_spi_tx_sclk_timer.sv
// SCLK half-period timer: produces the SCLK level and an end-of-bit pulse while enabled.
module sclk_timer
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic phase_o,
  output logic bit_end_o
);

  localparam int HW = cnt_w(CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] half_q;
  logic          phase_q;

  // Count CLK cycles within each SCLK half; flip the level at every half boundary, park high when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      half_q  <= '0;
      phase_q <= 1'b1;
    end else if (!en_i) begin
      half_q  <= '0;
      phase_q <= 1'b1;
    end else if (half_q == HALF_LAST) begin
      half_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      half_q  <= half_q + HW'(1);
    end
  end

  assign phase_o   = phase_q;
  // A bit ends on the last cycle of its low half.
  assign bit_end_o = en_i & ~phase_q & (half_q == HALF_LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// Parallel-in, serial-out frame transmitter for an SPI-style DAC (MSB first, zero padded).
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [DATA_W-1:0] SAMPLE,
  input  logic              SAMPLE_VALID,
  output logic              SAMPLE_READY,
  output logic              SCLK,
  output logic              SYNC_N,
  output logic              DIN
);

  localparam int BW = cnt_w(FRAME_W - 1);
  localparam int GW = cnt_w(GAP_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  state_e             state_q;
  logic [FRAME_W-1:0] shift_q;
  logic [BW-1:0]      bit_q;
  logic [GW-1:0]      gap_q;
  logic               shift_en_s;
  logic               phase_s;
  logic               bit_end_s;

  assign shift_en_s = (state_q == ST_SHIFT);

  sclk_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_timer (
    .clk_i     (CLK),
    .rst_ni    (RESETN),
    .en_i      (shift_en_s),
    .phase_o   (phase_s),
    .bit_end_o (bit_end_s)
  );

  // Frame sequencer: accept a sample in IDLE, shift it out bit by bit, then hold SYNC_N high for the gap.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (SAMPLE_VALID) begin
            shift_q <= FRAME_W'(SAMPLE);
            bit_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_end_s) begin
            shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
              gap_q   <= '0;
              state_q <= ST_GAP;
            end else begin
              bit_q   <= bit_q + BW'(1);
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            gap_q   <= gap_q + GW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          shift_q <= '0;
          bit_q   <= '0;
          gap_q   <= '0;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so nothing from the inputs reaches the pins combinationally.
  assign SAMPLE_READY = (state_q == ST_IDLE);
  assign SYNC_N       = ~shift_en_s;
  assign DIN          = shift_en_s & shift_q[FRAME_W-1];
  assign SCLK         = phase_s;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed self-checking bench for dac_spi_tx (default build plus a CLK_DIV=1 / GAP_CYC=1 build).
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [11:0] sample_a, sample_b;
  logic        valid_a, valid_b;
  logic        ready_a, sclk_a, sync_n_a, din_a;
  logic        ready_b, sclk_b, sync_n_b, din_b;

  int checks = 0;
  int errors = 0;

  dac_spi_tx #(.DATA_W(12), .FRAME_W(16), .CLK_DIV(2), .GAP_CYC(2)) dut_a (
    .CLK(clk), .RESETN(rst_n), .SAMPLE(sample_a), .SAMPLE_VALID(valid_a),
    .SAMPLE_READY(ready_a), .SCLK(sclk_a), .SYNC_N(sync_n_a), .DIN(din_a)
  );

  dac_spi_tx #(.DATA_W(12), .FRAME_W(16), .CLK_DIV(1), .GAP_CYC(1)) dut_b (
    .CLK(clk), .RESETN(rst_n), .SAMPLE(sample_b), .SAMPLE_VALID(valid_b),
    .SAMPLE_READY(ready_b), .SCLK(sclk_b), .SYNC_N(sync_n_b), .DIN(din_b)
  );

  // DAC-side receivers: shift in DIN on every SCLK falling edge while SYNC_N is low.
  logic        sclk_a_prev, sclk_b_prev;
  logic [31:0] cap_a = 32'd0, cap_b = 32'd0;
  int          nbits_a = 0, nbits_b = 0;

  always @(negedge clk) begin
    if (sclk_a_prev === 1'b1 && sclk_a === 1'b0 && sync_n_a === 1'b0) begin
      cap_a   <= {cap_a[30:0], din_a};
      nbits_a <= nbits_a + 1;
    end
    sclk_a_prev <= sclk_a;
  end

  always @(negedge clk) begin
    if (sclk_b_prev === 1'b1 && sclk_b === 1'b0 && sync_n_b === 1'b0) begin
      cap_b   <= {cap_b[30:0], din_b};
      nbits_b <= nbits_b + 1;
    end
    sclk_b_prev <= sclk_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake at cycle 0, then follow the frame until READY returns (or a planted reset / time bound).
  task automatic frame_a(input logic [11:0] s, input logic hold_valid, input int chg_at,
                         input int rst_at, output int ready_cyc, output int low_cnt);
    int cyc;
    sample_a  = s;
    valid_a   = 1'b1;
    ready_cyc = -1;
    low_cnt   = 0;
    chk("hs_ready_c0", 32'(ready_a), 32'd1);
    tick();
    cyc = 1;
    if (!hold_valid) valid_a = 1'b0;
    chk("sync_din_c1", 32'({sync_n_a, din_a, ready_a}), 32'b000);
    while (cyc < 200) begin
      if (ready_a) begin
        ready_cyc = cyc;
        break;
      end
      if (!sync_n_a) low_cnt++;
      if (cyc == chg_at) sample_a = 12'h000;
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 32'({sclk_a, sync_n_a, din_a, ready_a}), 32'b1101);
        ready_cyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  initial begin
    int rc, lc, rc1, lc1, n0, lows, cyc;
    rst_n    = 1'b1;
    sample_a = 12'h000;
    sample_b = 12'h000;
    valid_a  = 1'b0;
    valid_b  = 1'b0;
    #2 rst_n = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_outs_a", 32'({sclk_a, sync_n_a, din_a, ready_a}), 32'b1101);
    chk("rst_outs_b", 32'({sclk_b, sync_n_b, din_b, ready_b}), 32'b1101);
    rst_n = 1'b1;
    lows = 0;
    repeat (6) begin
      tick();
      if (!sclk_a || !sync_n_a || !ready_a || din_a) lows++;
    end
    chk("idle_quiet", 32'(lows), 32'd0);
    chk("idle_nbits", 32'(nbits_a), 32'd0);

    // Single frame
    n0 = nbits_a;
    frame_a(12'hA5C, 1'b0, -1, -1, rc, lc);
    chk("single_ready_cyc", 32'(rc), 32'd67);
    chk("single_sync_low", 32'(lc), 32'd64);
    chk("single_nbits", 32'(nbits_a - n0), 32'd16);
    chk("single_data", {16'h0, cap_a[15:0]}, 32'h0000_0A5C);

    // Back-to-back with VALID held high
    tick();
    n0 = nbits_a;
    frame_a(12'hFFF, 1'b1, -1, -1, rc1, lc1);
    chk("b2b1_ready_cyc", 32'(rc1), 32'd67);
    chk("b2b1_gap", 32'(rc1 - 1 - lc1), 32'd2);
    frame_a(12'h001, 1'b1, -1, -1, rc, lc);
    valid_a = 1'b0;
    chk("b2b2_ready_cyc", 32'(rc), 32'd67);
    chk("b2b2_sync_low", 32'(lc), 32'd64);
    chk("b2b_data", cap_a, 32'h0FFF_0001);
    chk("b2b_nbits", 32'(nbits_a - n0), 32'd32);
    repeat (4) tick();
    chk("b2b_no_third", 32'({sync_n_a, ready_a}), 32'b11);
    chk("b2b_nbits_after", 32'(nbits_a - n0), 32'd32);

    // SAMPLE changes mid-frame
    frame_a(12'h7FF, 1'b0, 10, -1, rc, lc);
    chk("chg_ready_cyc", 32'(rc), 32'd67);
    chk("chg_data", {16'h0, cap_a[15:0]}, 32'h0000_07FF);

    // Reset mid-frame, then a clean frame
    frame_a(12'h555, 1'b0, -1, 20, rc, lc);
    chk("rst_at_cyc", 32'(rc), 32'd20);
    tick();
    tick();
    chk("rst_hold_outs", 32'({sclk_a, sync_n_a, din_a, ready_a}), 32'b1101);
    rst_n = 1'b1;
    tick();
    chk("rst_release_idle", 32'({sclk_a, sync_n_a, ready_a}), 32'b111);
    n0 = nbits_a;
    frame_a(12'h123, 1'b0, -1, -1, rc, lc);
    chk("post_rst_ready_cyc", 32'(rc), 32'd67);
    chk("post_rst_nbits", 32'(nbits_a - n0), 32'd16);
    chk("post_rst_data", {16'h0, cap_a[15:0]}, 32'h0000_0123);

    // CLK_DIV=1, GAP_CYC=1 build
    n0 = nbits_b;
    sample_b = 12'h9C3;
    valid_b  = 1'b1;
    chk("b_hs_ready", 32'(ready_b), 32'd1);
    tick();
    valid_b = 1'b0;
    cyc = 1;
    rc  = -1;
    lc  = 0;
    while (cyc < 200) begin
      if (ready_b) begin
        rc = cyc;
        break;
      end
      if (!sync_n_b) lc++;
      tick();
      cyc++;
    end
    chk("b_ready_cyc", 32'(rc), 32'd34);
    chk("b_sync_low", 32'(lc), 32'd32);
    chk("b_nbits", 32'(nbits_b - n0), 32'd16);
    chk("b_data", {16'h0, cap_b[15:0]}, 32'h0000_09C3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial transmitter that takes 12-bit waveform samples from the function-generator datapath and shifts them out to an external SPI-style DAC. It samples data in parallel and drives a serial frame, the output-side counterpart of the generator's capture registers. One sample is accepted per frame through a valid/ready handshake. The block sits between the waveform sample source and the top-level DAC pins.

## Interface
- DATA_W, 12: sample width; frame carries DATA_W data bits.
- FRAME_W, 16: total bits per frame. The leading FRAME_W−DATA_W bits are zero pad. Must be ≥ DATA_W.
- CLK_DIV, 2: CLK cycles per SCLK half-period. Must be ≥ 1.
- GAP_CYC, 2: idle CLK cycles with SYNC_N high between frames. Must be ≥ 1.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESETN  in  1  asynchronous, active-low reset.
- SAMPLE  in  DATA_W  unsigned sample to transmit.
- SAMPLE_VALID  in  1  SAMPLE is valid.
- SAMPLE_READY  out  1  block can accept a sample this cycle.
- SCLK  out  1  serial clock to DAC; idles high.
- SYNC_N  out  1  frame select, active low.
- DIN  out  1  serial data, MSB first.

## Operation
- States are IDLE, SHIFT, and GAP.
- **IDLE:** SAMPLE_READY=1, SCLK=1, SYNC_N=1, DIN=0. On SAMPLE_VALID&&SAMPLE_READY, load shift register = {zero pad, SAMPLE}, clear bit counter, and go to SHIFT.
- **SHIFT:** SYNC_N=0, DIN=shift_reg[FRAME_W−1].
  - Each bit lasts 2·CLK_DIV cycles: SCLK high for the first CLK_DIV cycles, then low for CLK_DIV cycles.
  - The DAC samples on the SCLK falling edge, mid-bit.
  - At the end of each bit period, shift left by one and increment the bit counter.
  - After bit FRAME_W−1 completes, go to GAP.
- **GAP:** SYNC_N=1, SCLK=1, DIN=0 for GAP_CYC cycles, then go to IDLE.
- SAMPLE_READY is 1 only in IDLE.
- SAMPLE is captured only at the handshake. Changes to SAMPLE or SAMPLE_VALID during SHIFT or GAP have no effect.
- SAMPLE_VALID held high without READY waits; no sample is dropped or duplicated.
- All outputs are registered or decoded directly from registered state, with no combinational path from inputs to outputs.
- Counters: the half-period counter is wide enough for CLK_DIV−1. The bit counter is wide enough for FRAME_W−1 and wraps to 0 on frame end.

## Timing
- Reset values: SAMPLE_READY=1 (IDLE), SCLK=1, SYNC_N=1, DIN=0. The shift register and counters reset to 0.
- Handshake at cycle 0 → SYNC_N falls and DIN=frame MSB at cycle 1.
- SHIFT occupies cycles 1 … FRAME_W·2·CLK_DIV.
- GAP follows for GAP_CYC cycles.
- SAMPLE_READY returns to 1 at cycle FRAME_W·2·CLK_DIV + GAP_CYC + 1. With the defaults this is cycle 67, giving a 67-cycle minimum sample period.
- Back-to-back: if SAMPLE_VALID is high at that cycle, the next frame starts on the following cycle.
- DIN changes only coincident with an SCLK rising edge (bit boundary) or SYNC_N transitions. It is stable for the whole SCLK-low half.
- RESETN asserted mid-frame: outputs go to reset values immediately (asynchronously). The frame is abandoned and not resumed. After release, the block is in IDLE with SAMPLE_READY=1.

## Structure
- Package dac_spi_pkg holds:
  - the state enum (IDLE, SHIFT, GAP);
  - default constants DATA_W=12, FRAME_W=16, CLK_DIV=2, GAP_CYC=2;
  - a function computing counter widths (clog2).
- One sub-module, sclk_timer, owns the half-period counter. It outputs `phase` (SCLK level) and `bit_end` (one-cycle pulse at the end of each bit period). It is enabled only in SHIFT and clears when disabled.
- The top level holds the FSM, shift register, bit counter and gap counter.

## Test plan
- **Reset:** hold RESETN=0 → SCLK=1, SYNC_N=1, DIN=0, SAMPLE_READY=1; after release, state stays IDLE with no SCLK toggles.
- **Single frame:** SAMPLE=12'hA5C, VALID pulse at cycle 0.
  - On SCLK falling edges, the bench captures 16'h0A5C MSB first.
  - SYNC_N is low for cycles 1–64.
  - SAMPLE_READY=1 again at cycle 67.
- **Back-to-back:** VALID held high with SAMPLE=12'hFFF then 12'h001.
  - The frames are 16'h0FFF then 16'h0001.
  - Exactly 2 GAP cycles with SYNC_N high separate them.
  - No sample is repeated.
- **Input change mid-frame:** change SAMPLE to 12'h000 at cycle 10 of a 12'h7FF frame → the transmitted frame is still 16'h07FF.
- **Reset mid-frame:** assert RESETN at cycle 20 → SYNC_N=1 and SCLK=1 immediately. After release, a new 12'h123 frame transmits correctly as 16'h0123.
- **Parameter sweep:** CLK_DIV=1, GAP_CYC=1 → bit period of 2 cycles and READY returns at cycle 34. The captured data matches the input.
